// File: rtl/dmem_responder.sv
// Data-memory responder for a pipeline memory stage.
// Accepts one word load/store request at a time, waits LATENCY cycles, performs
// the access and holds the response until the requester consumes it.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_write        1 = store, 0 = load
//   req_addr         byte address (word aligned, index = addr[31:2])
//   req_wdata        store data
//   rsp_valid/ready  response handshake
//   rsp_rdata        load data, 0 for stores and errors
//   rsp_err          misaligned or out-of-range request
//   busy             responder is not idle
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               lat_write;
   logic [31:0]        lat_addr;
   logic [31:0]        lat_wdata;

   // Words are stored whole; with big-endian numbering the byte at the word
   // address is bits 31:24, so word accesses need no byte swapping.
   logic [31:0]        mem [DEPTH_WORDS];

   logic               addr_err_c;
   logic [IDX_W-1:0]   word_idx_c;
   logic               access_c;

   // Error decode and access strobe, all from the latched request
   assign addr_err_c = (lat_addr[1:0] != 2'b00) ||
                       (lat_addr[31:2] >= 30'(DEPTH_WORDS));
   assign word_idx_c = lat_addr[IDX_W+1:2];
   assign access_c   = (state == S_WAIT) && (cnt == '0);

   // Handshake/status decoded from the state register only
   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   // Control FSM with registered response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  cnt       <= CNT_W'(LATENCY);
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= addr_err_c;
                  rsp_rdata <= (lat_write || addr_err_c) ? 32'h0 : mem[word_idx_c];
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Storage write on the WAIT->RESP edge; not reset, and suppressed while
   // rst is high so a store pending at reset is discarded.
   always_ff @(posedge clk) begin
      if (!rst && access_c && lat_write && !addr_err_c) begin
         mem[word_idx_c] <= lat_wdata;
      end
   end

endmodule
